// File: rtl/render_unit_rect.sv
// Byte-serial PIXEL/RECT command rasteriser with screen clipping and valid/ready pixel output.
// Optional pixel-transfer counter output pix_count is enabled by defining RENDER_PIXCNT_EN.
module render_unit_rect #(
  parameter int COORD_W  = 8,
  parameter int COLOR_W  = 8,
  parameter int SCREEN_W = 256,
  parameter int SCREEN_H = 256
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               px_valid,
  input  logic               px_ready,
  output logic               busy,
  output logic               cmd_done,
  output logic               cmd_err
`ifdef RENDER_PIXCNT_EN
  ,
  output logic [31:0]        pix_count
`endif
);

  localparam int CB    = (COORD_W + 7) / 8;
  localparam int BW    = CB * 8;
  localparam int NB    = 4 * CB;
  localparam int CNT_W = $clog2(NB + 1);
  localparam logic [31:0] SW = SCREEN_W;
  localparam logic [31:0] SH = SCREEN_H;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t               r_state;
  logic [NB*8-1:0]      r_buf;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_pix;
  logic [COLOR_W-1:0]   r_color;
  logic [COORD_W-1:0]   r_ox, r_oy;
  logic                 r_end;
  logic                 r_cmd_ready;
  logic                 r_px_valid;
  logic [COORD_W-1:0]   r_px_x, r_px_y;
  logic [COLOR_W-1:0]   r_px_color;
  logic                 r_busy, r_done, r_err;

  logic [COORD_W-1:0]   w_x0, w_y0, w_w, w_h, w_ox, w_oy;
  logic [COORD_W:0]     w_x, w_y;
  logic [COLOR_W-1:0]   w_color;
  logic [CNT_W-1:0]     w_last_idx;
  logic                 w_acc, w_free, w_vis, w_last_col, w_last, w_zero, w_color_byte, w_step;

  // Field layout in r_buf: X0, Y0, W, H, each CB bytes little-endian.
  assign w_x0 = r_buf[0*BW +: COORD_W];
  assign w_y0 = r_buf[1*BW +: COORD_W];
  assign w_w  = r_buf[2*BW +: COORD_W];
  assign w_h  = r_buf[3*BW +: COORD_W];

  assign w_acc        = cmd_valid && r_cmd_ready;
  assign w_free       = !r_px_valid || px_ready;
  assign w_last_idx   = r_is_pix ? CNT_W'(2 * CB) : CNT_W'(4 * CB);
  assign w_color_byte = (r_state == LOAD) && w_acc && (r_cnt == w_last_idx);
  assign w_zero       = (w_w == '0) || (w_h == '0);

  // The colour byte cycle evaluates scan position (0,0) so the first pixel is out one cycle later.
  assign w_ox    = (r_state == LOAD) ? '0 : r_ox;
  assign w_oy    = (r_state == LOAD) ? '0 : r_oy;
  assign w_color = (r_state == LOAD) ? cmd_data[COLOR_W-1:0] : r_color;
  assign w_x     = {1'b0, w_x0} + {1'b0, w_ox};
  assign w_y     = {1'b0, w_y0} + {1'b0, w_oy};
  assign w_vis   = !w_x[COORD_W] && !w_y[COORD_W] && (32'(w_x) < SW) && (32'(w_y) < SH);

  assign w_last_col = (w_ox == w_w - COORD_W'(1));
  assign w_last     = w_last_col && (w_oy == w_h - COORD_W'(1));
  assign w_step     = (w_color_byte && !w_zero) || ((r_state == DRAW) && w_free && !r_end);

  // NOTE: every register here uses <= so all reads within the block see pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_is_pix    <= 1'b0;
      r_color     <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_end       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_px_valid  <= 1'b0;
      r_px_x      <= '0;
      r_px_y      <= '0;
      r_px_color  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_step) begin
        r_px_valid <= w_vis;
        if (w_vis) begin
          r_px_x     <= w_x[COORD_W-1:0];
          r_px_y     <= w_y[COORD_W-1:0];
          r_px_color <= w_color;
        end
        r_end <= w_last;
        if (w_last_col) begin
          r_ox <= '0;
          r_oy <= w_oy + COORD_W'(1);
        end else begin
          r_ox <= w_ox + COORD_W'(1);
          r_oy <= w_oy;
        end
      end else if (r_px_valid && px_ready) begin
        r_px_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_acc) begin
            r_cnt <= '0;
            if (cmd_data == 8'h01 || cmd_data == 8'h02) begin
              r_is_pix <= (cmd_data == 8'h01);
              r_busy   <= 1'b1;
              r_state  <= LOAD;
              if (cmd_data == 8'h01) begin
                r_buf[2*BW +: BW] <= BW'(1);
                r_buf[3*BW +: BW] <= BW'(1);
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_color_byte) begin
            r_color     <= cmd_data[COLOR_W-1:0];
            r_cmd_ready <= 1'b0;
            r_done      <= w_zero;
            r_state     <= w_zero ? DONE : DRAW;
          end else if (w_acc) begin
            for (int b = 0; b < NB; b++) begin
              if (r_cnt == CNT_W'(b)) r_buf[b*8 +: 8] <= cmd_data;
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAW: begin
          if (w_free && r_end) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RENDER_PIXCNT_EN
  logic [31:0] r_pix_count;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                     r_pix_count <= '0;
    else if (r_px_valid && px_ready)  r_pix_count <= r_pix_count + 32'd1;
  end

  assign pix_count = r_pix_count;
`endif

  assign cmd_ready = r_cmd_ready;
  assign px_x      = r_px_x;
  assign px_y      = r_px_y;
  assign px_color  = r_px_color;
  assign px_valid  = r_px_valid;
  assign busy      = r_busy;
  assign cmd_done  = r_done;
  assign cmd_err   = r_err;

endmodule
